// File: rtl/mem_slot_arbiter_if.sv
// Memory-port arbitration bundle: requests, lock extensions, slot ownership map
// and the registered grant/slot outputs of the arbiter.
interface mem_slot_arbiter_if #(
  parameter int NCH = 2,
  parameter int CW  = 3,
  parameter int IDW = 3
);
  logic [NCH-1:0]          req;
  logic [NCH-1:0]          lock;
  logic [(2**CW)*IDW-1:0]  slot_map;
  logic [CW-1:0]           slot;
  logic                    frame_start;
  logic [NCH-1:0]          gnt;
  logic [IDW-1:0]          gnt_id;
  logic                    gnt_valid;

  modport master (
    output req, lock, slot_map,
    input  slot, frame_start, gnt, gnt_id, gnt_valid
  );

  modport slave (
    input  req, lock, slot_map,
    output slot, frame_start, gnt, gnt_id, gnt_valid
  );
endinterface

// File: rtl/mem_slot_arbiter.sv
// Time-division memory port arbiter: per-slot owners, work-conserving round-robin
// reallocation of idle slots, and bounded lock extension of the current grant.
//   state   | meaning
//   idle    | valid_q=0, no channel owns the port this cycle
//   granted | valid_q=1, channel cur_q owns the port, lc_q cycles already extended
module mem_slot_arbiter #(
  parameter int NCH      = 2,
  parameter int CW       = 3,
  parameter int IDW      = 3,
  parameter int MAX_LOCK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_slot_arbiter_if.slave bus
);

  logic [CW-1:0]  slot_q, slot_d;
  logic [IDW-1:0] cur_q, cur_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [3:0]     lc_q, lc_d;
  logic           valid_q, valid_d;

  logic [NCH-1:0] gnt_vec;
  logic [IDW-1:0] owner;
  logic           owner_req;
  logic           hold;
  logic           hi_found, lo_found;
  logic [IDW-1:0] hi_pick, lo_pick, rr_pick;

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q  <= '0;
      cur_q   <= '0;
      rr_q    <= '0;
      lc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      cur_q   <= cur_d;
      rr_q    <= rr_d;
      lc_q    <= lc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    slot_d = slot_q + 1'b1;
    // The owner looked up is that of the slot being entered, so gnt lines up with slot.
    owner  = bus.slot_map[int'(slot_d)*IDW +: IDW];

    owner_req = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (owner == IDW'(i) && bus.req[i]) owner_req = 1'b1;
    end

    hold = valid_q && (|(bus.req & bus.lock & gnt_vec)) && (lc_q < 4'(MAX_LOCK - 1));

    // Descending scan leaves the lowest requester at/above rr, else the lowest overall.
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_pick  = '0;
    lo_pick  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        if (IDW'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_pick  = IDW'(i);
        end else begin
          lo_found = 1'b1;
          lo_pick  = IDW'(i);
        end
      end
    end
    rr_pick = hi_found ? hi_pick : lo_pick;

    cur_d   = '0;
    valid_d = 1'b0;
    lc_d    = '0;
    rr_d    = rr_q;
    if (hold) begin
      cur_d   = cur_q;
      valid_d = 1'b1;
      lc_d    = lc_q + 1'b1;
    end else if (owner_req) begin
      cur_d   = owner;
      valid_d = 1'b1;
    end else if (hi_found || lo_found) begin
      cur_d   = rr_pick;
      valid_d = 1'b1;
      rr_d    = (rr_pick == IDW'(NCH - 1)) ? '0 : rr_pick + 1'b1;
    end
  end

  always_comb begin
    gnt_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (valid_q && cur_q == IDW'(i)) gnt_vec[i] = 1'b1;
    end
  end

  assign bus.gnt         = gnt_vec;
  assign bus.gnt_id      = valid_q ? cur_q : '0;
  assign bus.gnt_valid   = valid_q;
  assign bus.slot        = slot_q;
  assign bus.frame_start = rst && (slot_q == '0);

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// Self-checking bench for mem_slot_arbiter: a 2-channel instance for TDM, lock and
// reset scenarios, and a 4-channel instance for round-robin fairness.
module tb_mem_slot_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_slot_arbiter_if #(.NCH(2), .CW(3), .IDW(3)) bus2 ();
  mem_slot_arbiter_if #(.NCH(4), .CW(3), .IDW(3)) bus4 ();

  mem_slot_arbiter #(.NCH(2), .CW(3), .IDW(3), .MAX_LOCK(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  mem_slot_arbiter #(.NCH(4), .CW(3), .IDW(3), .MAX_LOCK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  localparam logic [23:0] MAP_TDM  = 24'h208208; // owners 0,1,0,1,0,1,0,1
  localparam logic [23:0] MAP_LOCK = 24'h000008; // slot 1 owned by ch1, rest by ch0
  localparam logic [23:0] MAP_FREE = 24'hFFFFFF; // every slot free (owner 7)

  typedef struct {int ch; int slot;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic [7:0] eg;
  int n_chk = 0;
  int n_fail = 0;
  int exp_slot = 0;

  task automatic tick();
    @(posedge clk);
    exp_slot = rst ? (exp_slot + 1) % 8 : 0;
    @(negedge clk);
  endtask

  function automatic void expect_gnt(int ch);
    exp_t x;
    x.ch   = ch;
    x.slot = rst ? (exp_slot + 1) % 8 : 0;
    sb.push_back(x);
  endfunction

  function automatic logic [7:0] onehot(int ch);
    return (ch < 0) ? 8'd0 : 8'(1 << ch);
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus2.req = '0; bus2.lock = '0; bus2.slot_map = MAP_TDM;
    bus4.req = '0; bus4.lock = '0; bus4.slot_map = MAP_FREE;
    for (int i = 0; i < 3; i++) begin
      expect_gnt(-1);
      tick();
      e = sb.pop_front(); eg = onehot(e.ch);
      n_chk++;
      if ({bus2.gnt_valid, bus2.gnt_id, bus2.gnt} !== {1'b0, 3'd0, 2'b00} || bus2.slot !== 3'd0 || bus2.frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%b id=%0d valid=%b slot=%0d fs=%b, expected gnt=00 slot=0 fs=0",
                 bus2.gnt, bus2.gnt_id, bus2.gnt_valid, bus2.slot, bus2.frame_start);
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus2.frame_start !== 1'b1 || bus2.slot !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_release: slot=%0d fs=%b, expected slot=0 fs=1", bus2.slot, bus2.frame_start);
    end
    for (int i = 0; i < 9; i++) begin
      expect_gnt(-1);
      tick();
      e = sb.pop_front(); eg = onehot(e.ch);
      n_chk++;
      if (bus2.gnt !== eg[1:0] || bus2.gnt_valid !== 1'b0 || bus2.slot !== 3'(e.slot) || bus2.frame_start !== (e.slot == 0)) begin
        n_fail++;
        $display("FAIL free_run: gnt=%b slot=%0d fs=%b, expected gnt=00 slot=%0d fs=%b",
                 bus2.gnt, bus2.slot, bus2.frame_start, e.slot, e.slot == 0);
      end
    end
  endtask

  task automatic run2(string name, logic [1:0] req, logic [1:0] lock, logic [23:0] map, int ch);
    bus2.req = req; bus2.lock = lock; bus2.slot_map = map;
    expect_gnt(ch);
    tick();
    e = sb.pop_front(); eg = onehot(e.ch);
    n_chk++;
    if ({bus2.gnt_valid, bus2.gnt_id, bus2.gnt} !== {e.ch >= 0, 3'(e.ch < 0 ? 0 : e.ch), eg[1:0]} || bus2.slot !== 3'(e.slot)) begin
      n_fail++;
      $display("FAIL %s: gnt=%b id=%0d valid=%b slot=%0d, expected ch=%0d slot=%0d",
               name, bus2.gnt, bus2.gnt_id, bus2.gnt_valid, bus2.slot, e.ch, e.slot);
    end
  endtask

  task automatic test_tdm();
    for (int i = 0; i < 8; i++) run2("tdm", 2'b11, 2'b00, MAP_TDM, ((exp_slot + 1) % 2 == 0) ? 0 : 1);
    // rr is still 0 after pure owner grants, so free slots start at ch0
    run2("tdm_rr_untouched", 2'b11, 2'b00, MAP_FREE, 0);
    run2("tdm_rr_next", 2'b11, 2'b00, MAP_FREE, 1);
  endtask

  task automatic test_work_conserving();
    for (int i = 0; i < 8; i++) run2("wc_ch0", 2'b01, 2'b00, MAP_TDM, 0);
    for (int i = 0; i < 8; i++) run2("wc_ch1", 2'b10, 2'b00, MAP_TDM, 1);
    run2("wc_drop", 2'b00, 2'b00, MAP_TDM, -1);
  endtask

  task automatic test_round_robin();
    int seq[3] = '{0, 1, 3};
    bus4.slot_map = MAP_FREE;
    for (int i = 0; i < 9; i++) begin
      bus4.req = 4'b1011;
      expect_gnt(seq[i % 3]);
      tick();
      e = sb.pop_front(); eg = onehot(e.ch);
      n_chk++;
      if ({bus4.gnt_valid, bus4.gnt_id, bus4.gnt} !== {1'b1, 3'(e.ch), eg[3:0]} || bus4.slot !== 3'(e.slot)) begin
        n_fail++;
        $display("FAIL round_robin: gnt=%b id=%0d slot=%0d, expected ch=%0d slot=%0d",
                 bus4.gnt, bus4.gnt_id, bus4.slot, e.ch, e.slot);
      end
    end
    bus4.req = '0;
  endtask

  task automatic align_slot0(string name);
    for (int i = 0; i < 8 && exp_slot != 0; i++) run2(name, 2'b01, 2'b00, MAP_LOCK, 0);
    n_chk++;
    if (bus2.slot !== 3'd0) begin
      n_fail++;
      $display("FAIL %s_align: slot=%0d, expected 0 within 8 cycles", name, bus2.slot);
    end
  endtask

  task automatic test_lock_bound();
    int seq[6] = '{1, 1, 1, 1, 0, 0};
    align_slot0("lock");
    for (int i = 0; i < 6; i++) run2("lock_bound", 2'b11, 2'b10, MAP_LOCK, seq[i]);
    // lock from the non-granted channel does nothing
    run2("lock_foreign", 2'b11, 2'b10, MAP_LOCK, 0);
  endtask

  task automatic test_reset_mid_lock();
    run2("rml_prime_rr", 2'b01, 2'b00, MAP_FREE, 0);
    align_slot0("rml");
    run2("rml_lock1", 2'b11, 2'b10, MAP_LOCK, 1);
    run2("rml_lock2", 2'b11, 2'b10, MAP_LOCK, 1);
    rst = 1'b0;
    run2("rml_reset", 2'b11, 2'b10, MAP_LOCK, -1);
    n_chk++;
    if (bus2.frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rml_fs: fs=%b, expected 0 while in reset", bus2.frame_start);
    end
    rst = 1'b1;
    run2("rml_rr0", 2'b11, 2'b00, MAP_FREE, 0);
    run2("rml_rr1", 2'b11, 2'b00, MAP_FREE, 1);
    run2("rml_rr2", 2'b11, 2'b00, MAP_FREE, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_tdm();
    test_work_conserving();
    test_round_robin();
    test_lock_bound();
    test_reset_mid_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
